flash_requester: RTL and testbench

Initiator-side controller that drives the flash memory array's level-held request interface (read_enable / write_enable / erase, with addr, pid and data_in).
It accepts one command at a time from a process-side valid/ready port and sequences the array's enable/completion handshake. It also provides a timeout.
Each command returns a single response carrying read data and a status code.
It sits between the process scheduler and the memory array. It is the only block that toggles the array's request enables.

---
 rtl/flash_requester.sv | 160 ++++++++++++++++
 tb/tb_flash_requester.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_requester.sv
// Initiator-side sequencer for the flash array's level-held request enables.
// One command in flight: accept, set up address, hold enable until completion, wait for flags to clear, respond.
module flash_requester #(
  parameter int MAX_PID     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_pid,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic [7:0] mem_addr,
  output logic [3:0] mem_pid,
  output logic [7:0] mem_wdata,
  output logic       mem_read_enable,
  output logic       mem_write_enable,
  output logic       mem_erase,
  input  logic [7:0] mem_rdata,
  input  logic       mem_out_ready,
  input  logic       mem_rw_valid,
  input  logic       mem_erase_done,
  input  logic       mem_error,
  input  logic       mem_busy
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_RELEASE, S_RESP} state_t;

  localparam logic [1:0]  OP_RD  = 2'b00;
  localparam logic [1:0]  OP_WR  = 2'b01;
  localparam logic [1:0]  OP_ER  = 2'b10;
  localparam logic [1:0]  ST_OK  = 2'b00;
  localparam logic [1:0]  ST_ERR = 2'b01;
  localparam logic [1:0]  ST_TO  = 2'b10;
  localparam logic [1:0]  ST_ILL = 2'b11;
  localparam logic [3:0]  PID_MAX = 4'(MAX_PID);
  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYC);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  op_q;

  logic        done_sel, flags_any, cnt_hit, illegal;
  logic [15:0] cnt_nxt;
  logic        unused_busy;

  // busy is informational only; sequencing relies on the completion flags
  assign unused_busy = mem_busy;

  always_comb begin
    done_sel = 1'b0;
    case (op_q)
      OP_RD:   done_sel = mem_out_ready;
      OP_WR:   done_sel = mem_rw_valid;
      OP_ER:   done_sel = mem_erase_done;
      default: done_sel = 1'b0;
    endcase
  end

  assign flags_any = mem_out_ready | mem_rw_valid | mem_erase_done | mem_error;
  assign cnt_nxt   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign cnt_hit   = (cnt_nxt >= TO_LIM);
  assign illegal   = (cmd_op == 2'b11) || (cmd_pid > PID_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      op_q             <= '0;
      cmd_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_status       <= ST_OK;
      mem_addr         <= '0;
      mem_pid          <= '0;
      mem_wdata        <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_erase        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (illegal) begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_ILL;
              rsp_rdata  <= '0;
              state      <= S_RESP;
            end else begin
              op_q      <= cmd_op;
              mem_addr  <= cmd_addr;
              mem_pid   <= cmd_pid;
              mem_wdata <= (cmd_op == OP_WR) ? cmd_wdata : 8'h00;
              state     <= S_SETUP;
            end
          end
        end
        // address/pid/data already stable for a full cycle before the enable edge
        S_SETUP: begin
          mem_read_enable  <= (op_q == OP_RD);
          mem_write_enable <= (op_q == OP_WR);
          mem_erase        <= (op_q == OP_ER);
          cnt              <= '0;
          state            <= S_ISSUE;
        end
        S_ISSUE: begin
          if (mem_error || done_sel || cnt_hit) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_erase        <= 1'b0;
            cnt              <= '0;
            state            <= S_RELEASE;
            if (mem_error) begin
              rsp_status <= ST_ERR;
              rsp_rdata  <= '0;
            end else if (done_sel) begin
              rsp_status <= ST_OK;
              rsp_rdata  <= (op_q == OP_RD) ? mem_rdata : 8'h00;
            end else begin
              rsp_status <= ST_TO;
              rsp_rdata  <= '0;
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end
        // array must drop every completion/error flag before the next command
        S_RELEASE: begin
          if (!flags_any) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (cnt_hit) begin
            rsp_status <= ST_TO;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_requester.sv
// Directed bench for flash_requester: vector table against a behavioural array model, plus backpressure and async-reset sequences.
module tb_flash_requester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_addr = '0;
  logic [3:0] cmd_pid = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic [7:0] mem_addr, mem_wdata;
  logic [3:0] mem_pid;
  logic       mem_read_enable, mem_write_enable, mem_erase;
  logic [7:0] mem_rdata;
  logic       mem_out_ready, mem_rw_valid, mem_erase_done, mem_error, mem_busy;

  always #5 clk = ~clk;

  flash_requester #(.MAX_PID(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_pid(cmd_pid), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .mem_addr(mem_addr), .mem_pid(mem_pid), .mem_wdata(mem_wdata),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable), .mem_erase(mem_erase),
    .mem_rdata(mem_rdata), .mem_out_ready(mem_out_ready), .mem_rw_valid(mem_rw_valid),
    .mem_erase_done(mem_erase_done), .mem_error(mem_error), .mem_busy(mem_busy)
  );

  // array model modes: 0 flags one cycle after enable, 1 never completes,
  // 2 error+rw_valid together, 3 out_ready sticks high, 4 flags follow enables combinationally
  int   mode = 0;
  logic ro_q, rw_q, ed_q, err_q;
  assign mem_rdata = 8'hA5;
  assign mem_busy  = mem_read_enable | mem_write_enable | mem_erase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_q <= 1'b0; rw_q <= 1'b0; ed_q <= 1'b0; err_q <= 1'b0;
    end else begin
      case (mode)
        1: begin ro_q <= 1'b0; rw_q <= 1'b0; ed_q <= 1'b0; err_q <= 1'b0; end
        2: begin ro_q <= 1'b0; rw_q <= mem_write_enable; ed_q <= 1'b0; err_q <= mem_busy; end
        3: begin ro_q <= ro_q | mem_read_enable; rw_q <= 1'b0; ed_q <= 1'b0; err_q <= 1'b0; end
        default: begin
          ro_q <= mem_read_enable; rw_q <= mem_write_enable; ed_q <= mem_erase; err_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_out_ready  = ro_q;
    mem_rw_valid   = rw_q;
    mem_erase_done = ed_q;
    mem_error      = err_q;
    if (mode == 4) begin
      mem_out_ready  = mem_read_enable;
      mem_rw_valid   = mem_write_enable;
      mem_erase_done = mem_erase;
      mem_error      = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // transaction observation results
  logic       r_got, r_post_ok, r_seen_rise;
  logic [1:0] r_status;
  logic [7:0] r_rdata, r_rise_addr, r_rise_wd;
  logic [3:0] r_rise_pid;
  int         r_lat, r_overlap;
  int         en_cnt [3];

  task automatic do_txn(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] pid,
                        input logic [7:0] wd, input int md);
    logic [2:0] en, prev_en;
    logic [7:0] prev_addr, prev_wd;
    logic [3:0] prev_pid;
    int n;
    mode = md;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_pid = pid; cmd_wdata = wd;
    r_got = 1'b0; r_seen_rise = 1'b0; r_overlap = 0; r_lat = 1;
    r_rise_addr = '0; r_rise_pid = '0; r_rise_wd = '0; r_status = '0; r_rdata = '0;
    for (int i = 0; i < 3; i++) en_cnt[i] = 0;
    prev_en = '0; prev_addr = '0; prev_pid = '0; prev_wd = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!r_got && r_lat < 100) begin
      en = {mem_erase, mem_write_enable, mem_read_enable};
      if ($countones(en) > 1) r_overlap++;
      for (int i = 0; i < 3; i++) if (en[i]) en_cnt[i]++;
      if (en != 3'b000 && prev_en == 3'b000 && !r_seen_rise) begin
        r_seen_rise = 1'b1; r_rise_addr = prev_addr; r_rise_pid = prev_pid; r_rise_wd = prev_wd;
      end
      prev_en = en; prev_addr = mem_addr; prev_pid = mem_pid; prev_wd = mem_wdata;
      if (rsp_valid) begin
        r_got = 1'b1; r_status = rsp_status; r_rdata = rsp_rdata;
      end else begin
        @(negedge clk);
        r_lat++;
      end
    end
    r_post_ok = 1'b0;
    if (r_got) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      r_post_ok = !rsp_valid && cmd_ready;
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] addr;
    logic [3:0] pid;
    logic [7:0] wd;
    int         md;
    logic [1:0] st;
    logic [7:0] rd;
    int         which;   // 0 read, 1 write, 2 erase, 3 none
    int         en;      // cycles the selected enable is high
    logic [7:0] exp_wd;
    int         lat;     // cycles from acceptance to rsp_valid
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"read_ok",      2'b00, 8'h10, 4'd1, 8'h00, 0, 2'b00, 8'hA5, 0, 2, 8'h00, 6};
    vecs[1]  = '{"write_ok",     2'b01, 8'hFF, 4'd4, 8'h3C, 0, 2'b00, 8'h00, 1, 2, 8'h3C, 6};
    vecs[2]  = '{"erase_ok",     2'b10, 8'hFF, 4'd4, 8'h77, 0, 2'b00, 8'h00, 2, 2, 8'h00, 6};
    vecs[3]  = '{"bad_pid",      2'b00, 8'h20, 4'd5, 8'h00, 0, 2'b11, 8'h00, 3, 0, 8'h00, 1};
    vecs[4]  = '{"bad_op",       2'b11, 8'h21, 4'd0, 8'h55, 0, 2'b11, 8'h00, 3, 0, 8'h00, 1};
    vecs[5]  = '{"issue_tmo",    2'b00, 8'h30, 4'd2, 8'h00, 1, 2'b10, 8'h00, 0, 8, 8'h00, 11};
    vecs[6]  = '{"wr_err",       2'b01, 8'h40, 4'd3, 8'h9E, 2, 2'b01, 8'h00, 1, 2, 8'h9E, 6};
    vecs[7]  = '{"rd_err",       2'b00, 8'h41, 4'd3, 8'h00, 2, 2'b01, 8'h00, 0, 2, 8'h00, 6};
    vecs[8]  = '{"release_tmo",  2'b00, 8'h50, 4'd0, 8'h00, 3, 2'b10, 8'h00, 0, 2, 8'h00, 12};
    vecs[9]  = '{"read_min_lat", 2'b00, 8'h00, 4'd0, 8'h00, 4, 2'b00, 8'hA5, 0, 1, 8'h00, 4};
    vecs[10] = '{"erase_min_lat",2'b10, 8'h01, 4'd4, 8'hAA, 4, 2'b00, 8'h00, 2, 1, 8'h00, 4};

    // reset state
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_mem_bus", {12'd0, mem_addr, mem_pid, mem_wdata}, 32'd0);
    chk("rst_enables", {29'd0, mem_read_enable, mem_write_enable, mem_erase}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      do_txn(vecs[v].op, vecs[v].addr, vecs[v].pid, vecs[v].wd, vecs[v].md);
      chk({vecs[v].name, "_got"}, 32'(r_got), 32'd1);
      chk({vecs[v].name, "_status"}, 32'(r_status), 32'(vecs[v].st));
      chk({vecs[v].name, "_rdata"}, 32'(r_rdata), 32'(vecs[v].rd));
      chk({vecs[v].name, "_latency"}, 32'(r_lat), 32'(vecs[v].lat));
      chk({vecs[v].name, "_overlap"}, 32'(r_overlap), 32'd0);
      for (int i = 0; i < 3; i++)
        chk({vecs[v].name, "_en_cycles"}, 32'(en_cnt[i]), (i == vecs[v].which) ? 32'(vecs[v].en) : 32'd0);
      if (vecs[v].which != 3) begin
        chk({vecs[v].name, "_addr_setup"}, 32'(r_rise_addr), 32'(vecs[v].addr));
        chk({vecs[v].name, "_pid_setup"}, 32'(r_rise_pid), 32'(vecs[v].pid));
        chk({vecs[v].name, "_wdata_setup"}, 32'(r_rise_wd), 32'(vecs[v].exp_wd));
      end
      chk({vecs[v].name, "_post_idle"}, 32'(r_post_ok), 32'd1);
    end

    // response backpressure: outputs hold, new command is not taken until handshake
    begin
      int n;
      mode = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 8'h42; cmd_pid = 4'd2;
      @(negedge clk);
      cmd_op = 2'b01; cmd_addr = 8'h99; cmd_wdata = 8'h11;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("bp_hold", {13'd0, rsp_valid, rsp_status, rsp_rdata, cmd_ready, mem_addr}, {13'd0, 1'b1, 2'b00, 8'hA5, 1'b0, 8'h42});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_after_hs", {22'd0, rsp_valid, cmd_ready, mem_addr}, {22'd0, 1'b0, 1'b1, 8'h42});
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_next_accept", {16'd0, mem_addr, mem_wdata}, {16'd0, 8'h99, 8'h11});
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk("bp_next_status", {29'd0, rsp_valid, rsp_status}, {29'd0, 1'b1, 2'b00});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end

    // async reset with erase enable high
    begin
      int n;
      mode = 1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 8'h20; cmd_pid = 4'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!mem_erase && n < 20) begin @(negedge clk); n++; end
      chk("rr_erase_high", 32'(mem_erase), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rr_erase_async", 32'(mem_erase), 32'd0);
      chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mode = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("rr_no_rsp", {30'd0, rsp_valid, mem_busy}, 32'd0);
      end
      do_txn(2'b00, 8'h33, 4'd1, 8'h00, 0);
      chk("rr_read_after", {22'd0, r_got, r_status, r_rdata}, {22'd0, 1'b1, 2'b00, 8'hA5});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
